// File: rtl/dsp_ab_input_pipe.sv
`default_nettype none
// ============================================================================
// Module   : dsp_ab_input_pipe (with helper dsp_ab_reg_path)
// Brief    : A/B operand register stage (depth 0/1/2) in front of the 25x18
//            multiplier. Optional cascade mux/taps under macro AB_CASCADE_EN.
// Revision : 1.0 - initial release
// ============================================================================

module dsp_ab_reg_path #(
    parameter int WIDTH   = 30,
    parameter int DEPTH   = 1,
    parameter int CASCREG = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_src,
    input  logic             i_src_valid,
    input  logic             i_ce1,
    input  logic             i_ce2,
`ifdef AB_CASCADE_EN
    output logic [WIDTH-1:0] o_cout,
`endif
    output logic [WIDTH-1:0] o_dout,
    output logic             o_dout_valid
);

    if (DEPTH < 0 || DEPTH > 2) begin : g_bad_depth
        $error("dsp_ab_reg_path: DEPTH must be 0, 1 or 2 (got %0d)", DEPTH);
    end
    if (CASCREG < 0 || CASCREG > DEPTH) begin : g_bad_casc_hi
        $error("dsp_ab_reg_path: CASCREG %0d exceeds DEPTH %0d", CASCREG, DEPTH);
    end
    if (CASCREG == 0 && DEPTH != 0) begin : g_bad_casc_zero
        $error("dsp_ab_reg_path: CASCREG=0 requires DEPTH=0 (DEPTH=%0d)", DEPTH);
    end

    if (DEPTH == 0) begin : g_depth0
        logic w_unused_ce;
        assign w_unused_ce  = i_ce1 ^ i_ce2;
        assign o_dout       = i_src;
        assign o_dout_valid = i_src_valid;
`ifdef AB_CASCADE_EN
        assign o_cout       = i_src;
`endif
    end else if (DEPTH == 1) begin : g_depth1
        // Single-register mode uses the second stage, so ce1 is dead here.
        logic             w_unused_ce1;
        logic [WIDTH-1:0] r_s2;
        logic             r_s2_valid;

        assign w_unused_ce1 = i_ce1;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_s2       <= '0;
                r_s2_valid <= 1'b0;
            end else if (i_ce2) begin
                r_s2       <= i_src;
                r_s2_valid <= i_src_valid;
            end
        end

        assign o_dout       = r_s2;
        assign o_dout_valid = r_s2_valid;
`ifdef AB_CASCADE_EN
        assign o_cout       = r_s2;
`endif
    end else begin : g_depth2
        logic [WIDTH-1:0] r_s1;
        logic             r_s1_valid;
        logic [WIDTH-1:0] r_s2;
        logic             r_s2_valid;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_s1       <= '0;
                r_s1_valid <= 1'b0;
                r_s2       <= '0;
                r_s2_valid <= 1'b0;
            end else begin
                if (i_ce1) begin
                    r_s1       <= i_src;
                    r_s1_valid <= i_src_valid;
                end
                if (i_ce2) begin
                    r_s2       <= r_s1;
                    r_s2_valid <= r_s1_valid;
                end
            end
        end

        assign o_dout       = r_s2;
        assign o_dout_valid = r_s2_valid;
`ifdef AB_CASCADE_EN
        if (CASCREG == 1) begin : g_tap_s1
            assign o_cout = r_s1;
        end else begin : g_tap_s2
            assign o_cout = r_s2;
        end
`endif
    end

endmodule

module dsp_ab_input_pipe #(
    parameter int A_WIDTH      = 30,
    parameter int B_WIDTH      = 18,
    parameter int A_MULT_WIDTH = 25,
    parameter int AREG         = 1,
    parameter int BREG         = 1,
    parameter int ACASCREG     = 1,
    parameter int BCASCREG     = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [A_WIDTH-1:0]      a_in,
    input  logic [B_WIDTH-1:0]      b_in,
    input  logic                    a_valid_in,
    input  logic                    b_valid_in,
    input  logic                    cea1,
    input  logic                    cea2,
    input  logic                    ceb1,
    input  logic                    ceb2,
`ifdef AB_CASCADE_EN
    input  logic [A_WIDTH-1:0]      acin,
    input  logic [B_WIDTH-1:0]      bcin,
    input  logic                    a_sel,
    input  logic                    b_sel,
    output logic [A_WIDTH-1:0]      acout,
    output logic [B_WIDTH-1:0]      bcout,
`endif
    output logic [A_MULT_WIDTH-1:0] a_mult,
    output logic [B_WIDTH-1:0]      b_mult,
    output logic                    a_mult_valid,
    output logic                    b_mult_valid
);

    logic [A_WIDTH-1:0] w_a_src;
    logic [B_WIDTH-1:0] w_b_src;
    logic [A_WIDTH-1:0] w_a_dout;

`ifdef AB_CASCADE_EN
    assign w_a_src = a_sel ? acin : a_in;
    assign w_b_src = b_sel ? bcin : b_in;
`else
    assign w_a_src = a_in;
    assign w_b_src = b_in;
`endif

    dsp_ab_reg_path #(
        .WIDTH   (A_WIDTH),
        .DEPTH   (AREG),
        .CASCREG (ACASCREG)
    ) u_a_path (
        .clk          (clk),
        .rst          (rst),
        .i_src        (w_a_src),
        .i_src_valid  (a_valid_in),
        .i_ce1        (cea1),
        .i_ce2        (cea2),
`ifdef AB_CASCADE_EN
        .o_cout       (acout),
`endif
        .o_dout       (w_a_dout),
        .o_dout_valid (a_mult_valid)
    );

    dsp_ab_reg_path #(
        .WIDTH   (B_WIDTH),
        .DEPTH   (BREG),
        .CASCREG (BCASCREG)
    ) u_b_path (
        .clk          (clk),
        .rst          (rst),
        .i_src        (w_b_src),
        .i_src_valid  (b_valid_in),
        .i_ce1        (ceb1),
        .i_ce2        (ceb2),
`ifdef AB_CASCADE_EN
        .o_cout       (bcout),
`endif
        .o_dout       (b_mult),
        .o_dout_valid (b_mult_valid)
    );

    // Plain truncation: the high A bits never reach the multiplier.
    assign a_mult = w_a_dout[A_MULT_WIDTH-1:0];

    if (A_WIDTH > A_MULT_WIDTH) begin : g_a_hi
        logic w_unused_a_hi;
        assign w_unused_a_hi = ^w_a_dout[A_WIDTH-1:A_MULT_WIDTH];
    end

endmodule

`default_nettype wire

// File: tb/tb_dsp_ab_input_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsp_ab_input_pipe
// Brief    : Directed vector bench for dsp_ab_input_pipe at depths 2/2, 2/1, 0/0.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps

module tb_dsp_ab_input_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] a_in;
    logic [17:0] b_in;
    logic        a_valid_in, b_valid_in;
    logic        cea1, cea2, ceb1, ceb2;

    logic [24:0] a22, a21, a00;
    logic [17:0] b22, b21, b00;
    logic        av22, av21, av00, bv22, bv21, bv00;

`ifdef AB_CASCADE_EN
    logic [29:0] acin;
    logic [17:0] bcin;
    logic        a_sel, b_sel;
    logic [29:0] acout22, acout21, acout00;
    logic [17:0] bcout22, bcout21, bcout00;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dsp_ab_input_pipe #(.AREG(2), .BREG(2), .ACASCREG(1), .BCASCREG(2)) u22 (
        .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in),
        .a_valid_in(a_valid_in), .b_valid_in(b_valid_in),
        .cea1(cea1), .cea2(cea2), .ceb1(ceb1), .ceb2(ceb2),
`ifdef AB_CASCADE_EN
        .acin(acin), .bcin(bcin), .a_sel(a_sel), .b_sel(b_sel),
        .acout(acout22), .bcout(bcout22),
`endif
        .a_mult(a22), .b_mult(b22), .a_mult_valid(av22), .b_mult_valid(bv22)
    );

    dsp_ab_input_pipe #(.AREG(2), .BREG(1), .ACASCREG(2), .BCASCREG(1)) u21 (
        .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in),
        .a_valid_in(a_valid_in), .b_valid_in(b_valid_in),
        .cea1(cea1), .cea2(cea2), .ceb1(ceb1), .ceb2(ceb2),
`ifdef AB_CASCADE_EN
        .acin(acin), .bcin(bcin), .a_sel(a_sel), .b_sel(b_sel),
        .acout(acout21), .bcout(bcout21),
`endif
        .a_mult(a21), .b_mult(b21), .a_mult_valid(av21), .b_mult_valid(bv21)
    );

    dsp_ab_input_pipe #(.AREG(0), .BREG(0), .ACASCREG(0), .BCASCREG(0)) u00 (
        .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in),
        .a_valid_in(a_valid_in), .b_valid_in(b_valid_in),
        .cea1(cea1), .cea2(cea2), .ceb1(ceb1), .ceb2(ceb2),
`ifdef AB_CASCADE_EN
        .acin(acin), .bcin(bcin), .a_sel(a_sel), .b_sel(b_sel),
        .acout(acout00), .bcout(bcout00),
`endif
        .a_mult(a00), .b_mult(b00), .a_mult_valid(av00), .b_mult_valid(bv00)
    );

    typedef struct {
        logic [29:0] a;
        logic        av;
        logic [17:0] b;
        logic        bv;
        logic [3:0]  ce;      // {cea1, cea2, ceb1, ceb2}
        logic [24:0] e00a;    // depth-0 outputs, same cycle
        logic        e00av;
        logic [17:0] e00b;
        logic        e00bv;
        logic [24:0] e22a;    // after the next edge
        logic        e22av;
        logic [17:0] e22b;
        logic        e22bv;
        logic [17:0] e21b;
        logic        e21bv;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [29:0] a, input logic av, input logic [17:0] b,
                          input logic bv, input logic [3:0] ce);
        a_in = a; a_valid_in = av; b_in = b; b_valid_in = bv;
        {cea1, cea2, ceb1, ceb2} = ce;
    endtask

    initial begin
        //           a             av  b          bv  ce       e00a        av b          bv  e22a        av e22b       bv e21b       bv
        vecs[0] = '{30'h0ABCDEF1, 1, 18'h2A5A5, 1, 4'hF, 25'h0BCDEF1, 1, 18'h2A5A5, 1, 25'h0000000, 0, 18'h00000, 0, 18'h2A5A5, 1};
        vecs[1] = '{30'h3E000001, 1, 18'h15A5A, 1, 4'hF, 25'h0000001, 1, 18'h15A5A, 1, 25'h0BCDEF1, 1, 18'h2A5A5, 1, 18'h15A5A, 1};
        vecs[2] = '{30'h15555555, 0, 18'h3FFFF, 0, 4'hF, 25'h1555555, 0, 18'h3FFFF, 0, 25'h0000001, 1, 18'h15A5A, 1, 18'h3FFFF, 0};
        vecs[3] = '{30'h20000000, 1, 18'h00001, 1, 4'hF, 25'h0000000, 1, 18'h00001, 1, 25'h1555555, 0, 18'h3FFFF, 0, 18'h00001, 1};
        vecs[4] = '{30'h00000000, 0, 18'h00000, 0, 4'hF, 25'h0000000, 0, 18'h00000, 0, 25'h0000000, 1, 18'h00001, 1, 18'h00000, 0};
        vecs[5] = '{30'h000000AA, 1, 18'h000BB, 1, 4'hB, 25'h00000AA, 1, 18'h000BB, 1, 25'h0000000, 1, 18'h00000, 0, 18'h000BB, 1};
        vecs[6] = '{30'h00000055, 0, 18'h000CC, 1, 4'h6, 25'h0000055, 0, 18'h000CC, 1, 25'h00000AA, 1, 18'h00000, 0, 18'h000BB, 1};
        vecs[7] = '{30'h00000001, 1, 18'h00002, 1, 4'h0, 25'h0000001, 1, 18'h00002, 1, 25'h00000AA, 1, 18'h00000, 0, 18'h000BB, 1};
        vecs[8] = '{30'h00000000, 0, 18'h00000, 0, 4'hF, 25'h0000000, 0, 18'h00000, 0, 25'h00000AA, 1, 18'h000CC, 1, 18'h00000, 0};

`ifdef AB_CASCADE_EN
        acin = '0; bcin = '0; a_sel = 1'b0; b_sel = 1'b0;
`endif
        rst = 1'b1;
        set_in(30'h0, 1'b0, 18'h0, 1'b0, 4'hF);
        tick();
        chk("rst_a22", {7'd0, a22}, 32'd0);
        chk("rst_av22", {31'd0, av22}, 32'd0);
        chk("rst_b21", {14'd0, b21}, 32'd0);
        chk("rst_bv21", {31'd0, bv21}, 32'd0);
        #2 rst = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            set_in(vecs[i].a, vecs[i].av, vecs[i].b, vecs[i].bv, vecs[i].ce);
            #1;
            chk($sformatf("v%0d_a00", i),  {7'd0, a00},   {7'd0, vecs[i].e00a});
            chk($sformatf("v%0d_av00", i), {31'd0, av00}, {31'd0, vecs[i].e00av});
            chk($sformatf("v%0d_b00", i),  {14'd0, b00},  {14'd0, vecs[i].e00b});
            chk($sformatf("v%0d_bv00", i), {31'd0, bv00}, {31'd0, vecs[i].e00bv});
            tick();
            chk($sformatf("v%0d_a22", i),  {7'd0, a22},   {7'd0, vecs[i].e22a});
            chk($sformatf("v%0d_av22", i), {31'd0, av22}, {31'd0, vecs[i].e22av});
            chk($sformatf("v%0d_b22", i),  {14'd0, b22},  {14'd0, vecs[i].e22b});
            chk($sformatf("v%0d_bv22", i), {31'd0, bv22}, {31'd0, vecs[i].e22bv});
            chk($sformatf("v%0d_b21", i),  {14'd0, b21},  {14'd0, vecs[i].e21b});
            chk($sformatf("v%0d_bv21", i), {31'd0, bv21}, {31'd0, vecs[i].e21bv});
            chk($sformatf("v%0d_a21", i),  {7'd0, a21},   {7'd0, vecs[i].e22a});
        end

        // Asynchronous reset between edges, then first valid after release.
        set_in(30'h00123456, 1'b1, 18'h11111, 1'b1, 4'hF);
        tick();
        tick();
        chk("pre_rst_a22", {7'd0, a22}, 32'h00123456);
        chk("pre_rst_av22", {31'd0, av22}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_a22", {7'd0, a22}, 32'd0);
        chk("arst_av22", {31'd0, av22}, 32'd0);
        chk("arst_b22", {14'd0, b22}, 32'd0);
        chk("arst_bv22", {31'd0, bv22}, 32'd0);
        chk("arst_bv21", {31'd0, bv21}, 32'd0);
        chk("arst_a00", {7'd0, a00}, 32'h00123456);
        chk("arst_av00", {31'd0, av00}, 32'd1);
        set_in(30'h00000777, 1'b1, 18'h12345, 1'b1, 4'hF);
        tick();
        chk("in_rst_av22", {31'd0, av22}, 32'd0);
        #2 rst = 1'b0;
        tick();
        chk("rel1_av22", {31'd0, av22}, 32'd0);
        chk("rel1_b21", {14'd0, b21}, 32'h00012345);
        chk("rel1_bv21", {31'd0, bv21}, 32'd1);
        set_in(30'h0, 1'b0, 18'h0, 1'b0, 4'hF);
        tick();
        chk("rel2_a22", {7'd0, a22}, 32'h00000777);
        chk("rel2_av22", {31'd0, av22}, 32'd1);
        chk("rel2_b22", {14'd0, b22}, 32'h00012345);
        chk("rel2_bv22", {31'd0, bv22}, 32'd1);

        // Stall: A2 frozen while A1 keeps taking new data.
        set_in(30'h10, 1'b1, 18'h0, 1'b0, 4'hF);
        tick();
        set_in(30'h20, 1'b1, 18'h0, 1'b0, 4'hF);
        tick();
        chk("stall_pre_a22", {7'd0, a22}, 32'h10);
        for (int k = 1; k <= 3; k++) begin
            set_in(30'h30 + 30'(k), 1'b1, 18'h0, 1'b0, 4'hB);
            tick();
            chk($sformatf("stall%0d_a22", k), {7'd0, a22}, 32'h10);
            chk($sformatf("stall%0d_av22", k), {31'd0, av22}, 32'd1);
        end
        set_in(30'h44, 1'b0, 18'h0, 1'b0, 4'h7);
        tick();
        chk("unstall_a22", {7'd0, a22}, 32'h33);
        chk("unstall_av22", {31'd0, av22}, 32'd1);
        tick();
        chk("hold_a1_a22", {7'd0, a22}, 32'h33);

`ifdef AB_CASCADE_EN
        set_in(30'h3FFFFFFF, 1'b1, 18'h0A0A0, 1'b1, 4'hF);
        acin = 30'h1234567; a_sel = 1'b1;
        bcin = 18'h3C3C3;   b_sel = 1'b0;
        #1;
        chk("casc_acout00", {2'd0, acout00}, 32'h01234567);
        chk("casc_a00", {7'd0, a00}, 32'h01234567);
        chk("casc_bcout00", {14'd0, bcout00}, 32'h000A0A0);
        tick();
        chk("casc_acout22", {2'd0, acout22}, 32'h01234567);
        chk("casc_bcout21", {14'd0, bcout21}, 32'h000A0A0);
        a_sel = 1'b0; acin = '0;
        set_in(30'h0, 1'b0, 18'h0, 1'b0, 4'hF);
        tick();
        chk("casc_a22", {7'd0, a22}, 32'h01234567);
        chk("casc_acout21", {2'd0, acout21}, 32'h01234567);
        chk("casc_b22", {14'd0, b22}, 32'h000A0A0);
        chk("casc_bcout22", {14'd0, bcout22}, 32'h000A0A0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
